uart_rx_deframer: RTL
=====================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (min 2).
REQ-002 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: rx_dat_ser  in  1  asynchronous serial line, idle high.
REQ-005 SHALL have ports: divisor  in  16  clk cycles per bit.
REQ-006 SHALL have ports: rec_bit_order  in  1  0 = LSB first, 1 = MSB first.
REQ-007 SHALL have ports: rec_stop_bit_num  in  2  expected stop bits 1-3; 0 treated as 1.
REQ-008 SHALL have ports: rx_dat  out  8  last good received byte.
REQ-009 SHALL have ports: rx_dat_ev  out  1  one-cycle pulse, new byte on rx_dat.
REQ-010 SHALL have ports: frame_err  out  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have ports: parity_err  out  1  one-cycle pulse, parity mismatch.
REQ-012 SHALL have ports: rx_busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass rx_dat_ser through SYNC_STAGES flops reset to 1; all logic uses the synchronized signal.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE: a synchronized high-to-low transition SHALL enter START, latch divisor, rec_bit_order and rec_stop_bit_num, and load the half-bit count.
REQ-016 Configuration inputs changed mid-frame SHALL be ignored until the next start detection.
REQ-017 Divisor values below 4 SHALL be treated as 4.
REQ-018 Sample timing: with T0 = edge-detect cycle, the start bit SHALL be sampled at T0+floor(div/2) and bit k (k=0..) at T0+floor(div/2)+(k+1)*div.
REQ-019 START: a high sample SHALL be a false start and return to IDLE with no output pulse; a low sample SHALL enter DATA.
REQ-020 DATA: exactly 8 samples SHALL be taken, then PARITY (if enabled) or STOP.
REQ-021 Samples SHALL fill bit 0 upward when rec_bit_order=0, and bit 7 downward when rec_bit_order=1.
REQ-022 STOP: N stop samples SHALL be taken; any low stop sample SHALL mark the frame bad.
REQ-023 Good frame: one cycle after the final stop sample, rx_dat SHALL update and rx_dat_ev SHALL pulse high for exactly 1 cycle; then IDLE.
REQ-024 Bad frame: frame_err SHALL pulse 1 cycle, with rx_dat unchanged and no rx_dat_ev; state then goes to WAIT_IDLE.
REQ-025 WAIT_IDLE SHALL return to IDLE only after the synchronized line is sampled high (break/stuck-low handling).
REQ-026 A new start edge occurring in the cycle rx_dat_ev pulses SHALL be detected; back-to-back frames SHALL lose no byte.

Reset
REQ-027 rst SHALL force state=IDLE, synchronizers=1, rx_dat=8'h00, rx_dat_ev=0, frame_err=0, parity_err=0, rx_busy=0, counters=0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no event pulse; reception SHALL resume on the next falling edge after rst deasserts.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL be sampled after the data bits.
REQ-030 With UART_RX_PARITY_EN defined, a mismatch SHALL still update rx_dat and pulse rx_dat_ev, with parity_err pulsing in the same cycle.
REQ-031 With UART_RX_PARITY_EN defined, a frame with both framing and parity errors SHALL report frame_err only.
REQ-032 Macro UART_RX_PARITY_EN undefined: the PARITY state SHALL be absent, frames SHALL be start+8+stop, and parity_err SHALL be constant 0.

Verification
REQ-033 divisor=16, LSB first, 1 stop, byte 8'hA5 -> rx_dat=8'hA5, one rx_dat_ev pulse 1 cycle after the stop sample.
REQ-034 rec_bit_order=1, line bits 0,0,1,1,1,1,0,0 -> rx_dat=8'h3C.
REQ-035 divisor=16, 4-cycle low glitch -> no pulses, rx_busy drops by T0+9.
REQ-036 Stop bit driven low, then line held low 100 cycles -> one frame_err pulse; rx_dat keeps its prior value; no new start until the line goes high.
REQ-037 rst asserted during bit 4, then frame 8'h5A sent -> only 8'h5A reported.
REQ-038 UART_RX_PARITY_EN defined, 8'h01 with parity bit 0 -> rx_dat=8'h01, rx_dat_ev and parity_err pulse in the same cycle.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8-bit asynchronous serial receiver.
// The line is synchronized first. A falling edge starts a frame, and each bit is sampled near its centre.
// The receiver checks the stop bit(s) and reports good bytes, framing errors and, optionally, parity errors.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx_deframer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dat_ser,
  input  logic [15:0] divisor,
  input  logic        rec_bit_order,
  input  logic [1:0]  rec_stop_bit_num,
  output logic [7:0]  rx_dat,
  output logic        rx_dat_ev,
  output logic        frame_err,
  output logic        parity_err,
  output logic        rx_busy
);

  // A synchronizer shorter than two flops is not metastability-safe, so it is clamped to two.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [SYNC_N-1:0] sync_q;
  logic              rx_s;
  logic              rx_prev;
  logic              fall;

  logic [2:0]        state;
  logic [15:0]       cnt;
  logic [15:0]       div_q;
  logic              order_q;
  logic [1:0]        stop_left;
  logic [2:0]        bit_idx;
  logic [2:0]        wr_idx;
  logic [7:0]        shreg;
  logic              stop_bad;
  logic [15:0]       div_in_eff;
  logic              tick;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  // Input synchronizer chain; it idles at 1 to match the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rx_dat_ser};
    end
  end

  assign rx_s = sync_q[SYNC_N-1];

  // Previous synchronized level, used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // Decode the falling edge, the bit-period clamp, the sample tick and the byte write position.
  always_comb begin
    fall       = rx_prev & ~rx_s;
    div_in_eff = (divisor < 16'd4) ? 16'd4 : divisor;
    tick       = (cnt == '0);
    wr_idx     = order_q ? (3'd7 - bit_idx) : bit_idx;
  end

  assign rx_busy = (state != S_IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Frame sequencer: cnt counts down to the next sample point, and all outputs are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= '0;
      order_q   <= 1'b0;
      stop_left <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_bad  <= 1'b0;
      rx_dat    <= '0;
      rx_dat_ev <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_dat_ev <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (fall) begin
            state     <= S_START;
            div_q     <= div_in_eff;
            order_q   <= rec_bit_order;
            stop_left <= (rec_stop_bit_num == 2'd0) ? 2'd1 : rec_stop_bit_num;
            // The load value is one less than the half period, so the start sample lands on T0 + div/2.
            cnt       <= (div_in_eff >> 1) - 16'd1;
            stop_bad  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
              cnt     <= div_q - 16'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg[wr_idx] <= rx_s;
            cnt           <= div_q - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_bad <= (rx_s != ^shreg);
            cnt     <= div_q - 16'd1;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            cnt       <= div_q - 16'd1;
            stop_left <= stop_left - 2'd1;
            if (stop_left == 2'd1) begin
              // A framing error outranks a parity error and leaves rx_dat untouched.
              if (stop_bad | ~rx_s) begin
                frame_err <= 1'b1;
                state     <= S_WAIT_IDLE;
              end else begin
                rx_dat    <= shreg;
                rx_dat_ev <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
                state     <= S_IDLE;
              end
            end else begin
              stop_bad <= stop_bad | ~rx_s;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_WAIT_IDLE: begin
          // After a break or stuck-low line, re-arm only once the line is seen high again.
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
